// File: rtl/sid_regbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sid_regbus_pkg
//  Description : Shared types and constants for the SID register bus stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package sid_regbus_pkg;

    typedef logic [7:0] reg8_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
        logic       we;
        logic       oe;
        logic       res;
    } bus_i_t;

    typedef struct packed {
        logic cs_n;
    } cs_t;

    localparam int c_NUM_REGS = 25;

    typedef reg8_t regs_t [0:c_NUM_REGS-1];

    localparam logic [4:0] REG_LAST_WO = 5'h18;
    localparam logic [4:0] REG_POTX    = 5'h19;
    localparam logic [4:0] REG_POTY    = 5'h1A;
    localparam logic [4:0] REG_OSC3    = 5'h1B;
    localparam logic [4:0] REG_ENV3    = 5'h1C;

    localparam int c_DECAY_6581_DEFAULT = 8192;
    localparam int c_DECAY_8580_DEFAULT = 655360;
    localparam int c_CNT_W_DEFAULT      = 20;

    // Read-only registers whose readback also refreshes the bus latch
    function automatic logic is_readback(input logic [4:0] addr);
        return (addr >= REG_POTX) && (addr <= REG_ENV3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_bus_decay.sv
`default_nettype none
// ============================================================================
//  Module      : sid_bus_decay
//  Description : SID data bus latch with model-dependent decay to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_bus_decay #(
    parameter int DECAY_6581 = 8192,
    parameter int DECAY_8580 = 655360,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       model,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       tick,
    output logic [7:0] latch
);

    localparam logic [CNT_W-1:0] c_RELOAD_6581 = CNT_W'(DECAY_6581);
    localparam logic [CNT_W-1:0] c_RELOAD_8580 = CNT_W'(DECAY_8580);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_latch;

    // A reload takes priority over a coincident tick, so no decrement that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_latch <= '0;
        end else if (load) begin
            r_latch <= load_data;
            r_cnt   <= model ? c_RELOAD_8580 : c_RELOAD_6581;
        end else if (tick) begin
            if (r_cnt > c_ONE) begin
                r_cnt <= r_cnt - c_ONE;
            end else if (r_cnt == c_ONE) begin
                r_cnt   <= '0;
                r_latch <= '0;
            end
        end
    end

    assign latch = r_latch;

endmodule
`default_nettype wire

// File: rtl/sid_regbus.sv
`default_nettype none
// ============================================================================
//  Module      : sid_regbus
//  Description : SID register file, write strobe, readback mux and bus latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_regbus
    import sid_regbus_pkg::*;
#(
    parameter int DECAY_6581 = c_DECAY_6581_DEFAULT,
    parameter int DECAY_8580 = c_DECAY_8580_DEFAULT,
    parameter int CNT_W      = c_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2,
    input  bus_i_t     bus_i,
    input  cs_t        cs,
    input  logic       model,
    input  logic [7:0] potx,
    input  logic [7:0] poty,
    input  logic [7:0] osc3,
    input  logic [7:0] env3,
    output logic [7:0] data_o,
    output regs_t      regs,
    output logic       wr_stb,
    output logic [4:0] wr_addr
);

    logic       r_we_prev;
    logic       r_oe_prev;
    logic       r_phi2_prev;
    regs_t      r_regs;
    logic [7:0] r_data_o;
    logic       r_wr_stb;
    logic [4:0] r_wr_addr;

    logic       w_rst;
    logic       w_sel;
    logic       w_wr;
    logic       w_rd_reload;
    logic       w_tick;
    logic [7:0] w_latch;
    logic [7:0] w_rd_val;
    logic [7:0] w_load_data;

    assign w_rst       = rst | bus_i.res;
    assign w_sel       = ~cs.cs_n;
    assign w_wr        = bus_i.we & ~r_we_prev & w_sel;
    assign w_rd_reload = bus_i.oe & ~r_oe_prev & w_sel & is_readback(bus_i.addr);
    assign w_tick      = r_phi2_prev & ~phi2;
    assign w_load_data = w_wr ? bus_i.data : w_rd_val;

    always_comb begin
        w_rd_val = w_latch;
        case (bus_i.addr)
            REG_POTX: w_rd_val = potx;
            REG_POTY: w_rd_val = poty;
            REG_OSC3: w_rd_val = osc3;
            REG_ENV3: w_rd_val = env3;
            default:  w_rd_val = w_latch;
        endcase
    end

    // Edge history keeps tracking through reset so a strobe held across reset release is not a new edge
    always_ff @(posedge clk) begin
        r_we_prev   <= bus_i.we;
        r_oe_prev   <= bus_i.oe;
        r_phi2_prev <= phi2;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_data_o  <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (w_wr && (bus_i.addr == 5'(i))) begin
                    r_regs[i] <= bus_i.data;
                end
            end
            if (w_wr && (bus_i.addr <= REG_LAST_WO)) begin
                r_wr_stb  <= 1'b1;
                r_wr_addr <= bus_i.addr;
            end
            if (bus_i.oe && w_sel) begin
                r_data_o <= w_rd_val;
            end
        end
    end

    sid_bus_decay #(
        .DECAY_6581 (DECAY_6581),
        .DECAY_8580 (DECAY_8580),
        .CNT_W      (CNT_W)
    ) u_decay (
        .clk       (clk),
        .rst       (w_rst),
        .model     (model),
        .load      (w_wr | w_rd_reload),
        .load_data (w_load_data),
        .tick      (w_tick),
        .latch     (w_latch)
    );

    assign data_o  = r_data_o;
    assign regs    = r_regs;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_sid_regbus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sid_regbus
//  Description : Self-checking bench for sid_regbus (vectors, corners, random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_regbus;
    import sid_regbus_pkg::*;

    // Decay lengths scaled down so full expiry fits in a short run
    localparam int T_D65 = 40;
    localparam int T_D85 = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       phi2;
    bus_i_t     bus;
    cs_t        cs;
    logic       model;
    logic [7:0] potx, poty, osc3, env3;
    logic [7:0] data_o;
    regs_t      regs;
    logic       wr_stb;
    logic [4:0] wr_addr;

    int checks = 0;
    int errors = 0;

    sid_regbus #(
        .DECAY_6581 (T_D65),
        .DECAY_8580 (T_D85),
        .CNT_W      (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .phi2    (phi2),
        .bus_i   (bus),
        .cs      (cs),
        .model   (model),
        .potx    (potx),
        .poty    (poty),
        .osc3    (osc3),
        .env3    (env3),
        .data_o  (data_o),
        .regs    (regs),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr)
    );

    always #5 clk = ~clk;

    // Reference model: latch value plus its age in phi2 falls since last load
    logic [7:0] m_regs [25];
    logic [7:0] m_lval, m_data_o;
    logic [4:0] m_wr_addr;
    logic       m_stb;
    int         m_age, m_life;
    bit         m_we_prev = 1'b0, m_oe_prev = 1'b0, m_phi_prev = 1'b0;

    function automatic logic [7:0] m_latch();
        return (m_age >= m_life) ? 8'h00 : m_lval;
    endfunction

    function automatic logic [7:0] readback(input logic [4:0] a, input logic [7:0] cur);
        case (a)
            5'h19:   return potx;
            5'h1A:   return poty;
            5'h1B:   return osc3;
            5'h1C:   return env3;
            default: return cur;
        endcase
    endfunction

    task automatic m_load(input logic [7:0] v);
        m_lval = v;
        m_age  = 0;
        m_life = model ? T_D85 : T_D65;
    endtask

    task automatic clk_step();
        logic [7:0] cur, rv;
        bit sel, wr, rde, tk;
        int idx;
        @(posedge clk);
        cur = m_latch();
        sel = !cs.cs_n;
        wr  = bus.we && !m_we_prev && sel;
        rde = bus.oe && !m_oe_prev && sel;
        tk  = m_phi_prev && !phi2;
        rv  = readback(bus.addr, cur);
        idx = int'(bus.addr);
        if (rst || bus.res) begin
            for (int i = 0; i < 25; i++) m_regs[i] = 8'h00;
            m_lval = 8'h00; m_age = 0; m_life = 0;
            m_data_o = 8'h00; m_stb = 1'b0; m_wr_addr = 5'h00;
        end else begin
            m_stb = 1'b0;
            if (bus.oe && sel) m_data_o = rv;
            if (wr) begin
                if (idx < 25) begin
                    m_regs[idx] = bus.data;
                    m_stb       = 1'b1;
                    m_wr_addr   = bus.addr;
                end
                m_load(bus.data);
            end else if (rde && idx >= 'h19 && idx <= 'h1C) begin
                m_load(rv);
            end else if (tk) begin
                m_age++;
            end
        end
        m_we_prev  = bus.we;
        m_oe_prev  = bus.oe;
        m_phi_prev = phi2;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        int bad = -1;
        checks++;
        for (int i = 0; i < 25; i++)
            if (bad < 0 && regs[i] !== m_regs[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: regs[%0d] got %0h expected %0h", name, bad, regs[bad], m_regs[bad]);
        end
    endtask

    task automatic phi_fall();
        phi2 = 1'b1; clk_step();
        phi2 = 1'b0; clk_step();
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
        bus.oe = 1'b1; bus.addr = a;
        clk_step();
        chk(name, data_o, exp);
        bus.oe = 1'b0;
        clk_step();
    endtask

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        logic       we, oe, cs_n;
        logic [7:0] exp_do;
        logic       exp_stb;
        logic [4:0] exp_wa;
    } vec_t;

    vec_t tbl [19];

    initial begin
        tbl[0]  = '{5'h04, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'h04};
        tbl[1]  = '{5'h04, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'h00};
        tbl[2]  = '{5'h04, 8'h41, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'h00};
        tbl[3]  = '{5'h04, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'h00};
        tbl[4]  = '{5'h19, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 5'h00};
        tbl[5]  = '{5'h00, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 5'h00};
        tbl[6]  = '{5'h00, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 5'h00};
        tbl[7]  = '{5'h1A, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 5'h00};
        tbl[8]  = '{5'h00, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 5'h00};
        tbl[9]  = '{5'h00, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 5'h00};
        tbl[10] = '{5'h1F, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b0, 5'h00};
        tbl[11] = '{5'h04, 8'hEE, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 5'h00};
        tbl[12] = '{5'h04, 8'hEE, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 5'h00};
        tbl[13] = '{5'h05, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 5'h00};
        tbl[14] = '{5'h05, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 5'h00};
        tbl[15] = '{5'h05, 8'hEE, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 5'h00};
        tbl[16] = '{5'h1C, 8'hEE, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 5'h00};
        tbl[17] = '{5'h1C, 8'hEE, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b0, 5'h00};
        tbl[18] = '{5'h1D, 8'hEE, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 5'h00};

        rst = 1'b1; phi2 = 1'b0; model = 1'b0;
        bus = '0; cs.cs_n = 1'b0;
        potx = 8'h7F; poty = 8'h3C; osc3 = 8'h9A; env3 = 8'hE1;
        clk_step(); clk_step();
        rst = 1'b0;
        clk_step();
        chk("reset data_o", data_o, 8'h00);
        chk("reset wr_stb", wr_stb, 1'b0);
        chk("reset wr_addr", wr_addr, 5'h00);
        chk_regs("reset regs");

        for (int i = 0; i < 19; i++) begin
            bus.addr = tbl[i].addr; bus.data = tbl[i].data;
            bus.we = tbl[i].we; bus.oe = tbl[i].oe; cs.cs_n = tbl[i].cs_n;
            clk_step();
            chk($sformatf("vec%0d data_o", i), data_o, tbl[i].exp_do);
            chk($sformatf("vec%0d wr_stb", i), wr_stb, tbl[i].exp_stb);
            if (tbl[i].exp_stb) chk($sformatf("vec%0d wr_addr", i), wr_addr, tbl[i].exp_wa);
        end
        bus = '0; cs.cs_n = 1'b0;
        clk_step();
        chk("vec regs[4]", regs[4], 8'h41);
        chk("vec regs[5] deselected", regs[5], 8'h00);
        chk_regs("vec regs");

        // Boundary addresses: last writable vs first read-only
        bus.we = 1'b1; bus.addr = 5'h18; bus.data = 8'hC3;
        clk_step();
        chk("wr 0x18 stb", wr_stb, 1'b1);
        chk("wr 0x18 addr", wr_addr, 5'h18);
        bus.we = 1'b0; clk_step();
        chk("wr 0x18 regs", regs[24], 8'hC3);
        bus.we = 1'b1; bus.addr = 5'h19; bus.data = 8'h11;
        clk_step();
        chk("wr 0x19 stb", wr_stb, 1'b0);
        bus.we = 1'b0; clk_step();
        chk_regs("wr 0x19 regs");

        // 6581 decay, with the write landing on a phi2 fall
        model = 1'b0;
        phi2 = 1'b1; clk_step();
        phi2 = 1'b0; bus.we = 1'b1; bus.addr = 5'h1F; bus.data = 8'hA5;
        clk_step();
        bus.we = 1'b0; clk_step();
        repeat (T_D65 - 1) phi_fall();
        read_chk("6581 before expiry", 5'h1D, 8'hA5);
        phi_fall();
        read_chk("6581 at expiry", 5'h1D, 8'h00);

        // 8580 decay; model is only sampled at reload
        model = 1'b1;
        bus.we = 1'b1; bus.addr = 5'h1E; bus.data = 8'h55;
        clk_step();
        bus.we = 1'b0; model = 1'b0; clk_step();
        repeat (T_D65) phi_fall();
        read_chk("8580 past 6581 length", 5'h1D, 8'h55);
        repeat (T_D85 - T_D65 - 1) phi_fall();
        read_chk("8580 before expiry", 5'h00, 8'h55);
        phi_fall();
        read_chk("8580 at expiry", 5'h00, 8'h00);

        // rst coincident with a write edge and nonzero prior state
        read_chk("pre-reset read", 5'h19, 8'h7F);
        rst = 1'b1; bus.we = 1'b1; bus.addr = 5'h02; bus.data = 8'h33;
        clk_step();
        chk("rst data_o", data_o, 8'h00);
        chk("rst wr_stb", wr_stb, 1'b0);
        chk("rst regs[4]", regs[4], 8'h00);
        chk("rst regs[2]", regs[2], 8'h00);
        rst = 1'b0; clk_step();
        chk("rst release wr_stb", wr_stb, 1'b0);
        chk_regs("rst regs");
        bus.we = 1'b0; clk_step();

        // bus res coincident with a write edge
        bus.res = 1'b1; bus.we = 1'b1; bus.addr = 5'h03; bus.data = 8'h77;
        clk_step();
        chk("res wr_stb", wr_stb, 1'b0);
        chk("res regs[3]", regs[3], 8'h00);
        bus.res = 1'b0; clk_step();
        chk("res release wr_stb", wr_stb, 1'b0);
        read_chk("res latch", 5'h00, 8'h00);
        bus.we = 1'b0; clk_step();

        // Randomized traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            bus.addr = 5'($urandom_range(0, 31));
            bus.data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.we = ~bus.we;
            if ($urandom_range(0, 3) == 0) bus.oe = ~bus.oe;
            if ($urandom_range(0, 1) == 0) phi2 = ~phi2;
            if ($urandom_range(0, 63) == 0) model = ~model;
            cs.cs_n = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            bus.res = ($urandom_range(0, 299) == 0);
            potx = 8'($urandom); poty = 8'($urandom);
            osc3 = 8'($urandom); env3 = 8'($urandom);
            clk_step();
            chk("rand data_o", data_o, m_data_o);
            chk("rand wr_stb", wr_stb, m_stb);
            if (m_stb) chk("rand wr_addr", wr_addr, m_wr_addr);
            if (n % 16 == 0) chk_regs("rand regs");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
